otp_generator: RTL and testbench
================================

Name: otp_generator

Overview:
- Upstream stage of the OTP authentication FSM.
- Produces the 4-digit BCD one-time password on `lfsr_digit[15:0]` and pulses `lfsr_latch` for one cycle when the value is valid.
- Digits come from a 16-bit Galois LFSR. Each cycle's low nibble is rejection-sampled: only values 0..9 are accepted, so every digit is true decimal with no modulo bias.
- `gen_req` is driven at top level while the authentication FSM is in its generate state.

Parameters:
- SEED, 16'hACE1: reset value of the LFSR. Also the recovery value if the LFSR ever holds 0.
- TAPS, 16'hB400: Galois feedback mask, right-shift form.
- FREE_RUN, 1: 1 = LFSR also advances in IDLE and DONE (entropy from request timing); 0 = LFSR advances only in COLLECT (deterministic, used for verification).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- gen_req  input  1  level request for a new OTP; sampled only in IDLE
- seed_load  input  1  load seed_value into the LFSR this cycle
- seed_value  input  16  seed to load
- lfsr_digit  output  16  BCD OTP; [15:12] = first digit accepted, [3:0] = last
- lfsr_latch  output  1  one-cycle strobe: lfsr_digit is valid and new
- busy  output  1  high while in COLLECT
- reject_cnt  output  8  rejected nibbles for the current/last request; saturates at 255

Behaviour:
- Reset (async, active-low): LFSR=SEED, state=IDLE, lfsr_digit=0, lfsr_latch=0, busy=0, reject_cnt=0, digit index=0.
- LFSR step: next = (s>>1) ^ (s[0] ? TAPS : 0).
- States: IDLE, COLLECT, DONE (2-bit encoding).
- IDLE:
  - gen_req=1 -> COLLECT next cycle.
  - On entry to COLLECT: clear reject_cnt and digit index; lfsr_digit keeps its old value until DONE.
- COLLECT:
  - Every cycle, sample the current LFSR state's bits [3:0], then advance the LFSR.
  - nibble <= 9: write it to the slot given by the index (0 -> [15:12] ... 3 -> [3:0]) and increment the index.
  - nibble >= 10: increment reject_cnt (saturating).
  - When the 4th digit is accepted -> DONE next cycle.
  - The slot shadow register is separate from lfsr_digit; lfsr_digit updates only on entry to DONE.
- DONE: lasts exactly one cycle. lfsr_latch=1, lfsr_digit=new OTP. Then -> IDLE, regardless of gen_req.
- Latency: gen_req seen in IDLE at cycle N gives COLLECT N+1 to N+k, where k = 4 + number of rejects. DONE and lfsr_latch are at N+k+1.
- busy=1 exactly in COLLECT. lfsr_digit holds its value between strobes.
- gen_req during COLLECT or DONE: ignored. A request still high when the FSM returns to IDLE starts a new collection the following cycle.
- seed_load: highest priority on the LFSR register, in any state.
  - The LFSR takes seed_value; no step that cycle; no sample that cycle, even in COLLECT.
  - COLLECT continues from the new state; digits already accepted are kept.
- Zero lock: if the LFSR would hold 0 (seed_value=0, or a computed 0), load SEED instead. A sample taken from a zero state is never used.
- Reset mid-COLLECT: everything returns to reset values; no lfsr_latch is issued.

Decomposition:
- Shared package:
  - state encoding constants IDLE/COLLECT/DONE
  - DEFAULT_SEED and DEFAULT_TAPS
  - BCD_MAX=9
- One natural sub-module, lfsr16_galois: clk, reset, step, load, load_value, state_out, with zero-lock recovery built in.
- The FSM, slot register and reject counter stay in otp_generator.

Test Plan:
- Reset -> lfsr_digit=16'h0000, lfsr_latch=0, busy=0, reject_cnt=0; internal LFSR state = 16'hACE1.
- FREE_RUN=0, seed_load 16'h0001, then gen_req.
  - Samples 1,0,0,0 from states 0001/B400/5A00/2D00.
  - lfsr_latch pulses once, 5 cycles after gen_req is seen, with lfsr_digit=16'h1000 and reject_cnt=0.
- FREE_RUN=0, seed 16'h000F, then gen_req.
  - F is rejected; then 7,3,1,0 from B407/EE03/C301/D580.
  - lfsr_digit=16'h7310, reject_cnt=1, busy high for 5 cycles.
- seed_load with 16'h0000 -> LFSR state = 16'hACE1; the next OTP equals the OTP obtained from seed 16'hACE1.
- gen_req toggled during COLLECT -> no extra strobe.
  - gen_req held high -> back-to-back OTPs, exactly one lfsr_latch per OTP.
  - Every digit of 200 OTPs is <= 9.
- Reset asserted mid-COLLECT after 2 accepted digits -> no strobe, lfsr_digit=0; after release, a fresh request yields the full 4-digit OTP from SEED.

Source files
------------

// File: rtl/otp_generator_pkg.sv
// Shared state encoding, LFSR defaults and Galois step helper for the OTP generator.
// Combinational helpers only; no latency, no flow control.
package otp_generator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } otp_state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [3:0]  BCD_MAX      = 4'd9;

  function automatic logic [15:0] galois_step(input logic [15:0] s, input logic [15:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 16'h0000);
  endfunction

endpackage

// File: rtl/otp_generator_lfsr.sv
// 16-bit right-shift Galois LFSR; load beats step, and an all-zero next state becomes SEED.
// State updates one cycle after step/load; no backpressure.
module lfsr16_galois
  import otp_generator_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter logic [15:0] TAPS = DEFAULT_TAPS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] state_out
);

  logic [15:0] nxt;

  always_comb begin
    nxt = state_out;
    if (load) begin
      nxt = load_value;
    end else if (step) begin
      nxt = galois_step(state_out, TAPS);
    end
    // The all-zero state is a fixed point of the LFSR, so never let it in.
    if (nxt == 16'h0000) begin
      nxt = SEED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_out <= SEED;
    end else begin
      state_out <= nxt;
    end
  end

endmodule

// File: rtl/otp_generator.sv
// Collects four rejection-sampled BCD digits from an LFSR and strobes them out as a one-time password.
// Strobe comes 4 + rejects cycles after the request is taken in IDLE; requests outside IDLE are ignored.
module otp_generator
  import otp_generator_pkg::*;
#(
  parameter logic [15:0] SEED     = DEFAULT_SEED,
  parameter logic [15:0] TAPS     = DEFAULT_TAPS,
  parameter bit          FREE_RUN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gen_req,
  input  logic        seed_load,
  input  logic [15:0] seed_value,
  output logic [15:0] lfsr_digit,
  output logic        lfsr_latch,
  output logic        busy,
  output logic [7:0]  reject_cnt
);

  otp_state_t  state;
  logic [1:0]  idx;
  logic [15:0] slot;
  logic [15:0] slot_nxt;
  logic [15:0] lfsr_state;
  logic [3:0]  nib;
  logic        lfsr_step;
  logic        sample_ok;
  logic        accept;

  assign lfsr_step = FREE_RUN || (state == COLLECT);
  // A cycle that reloads the seed produces no sample; a zero state is never sampled.
  assign sample_ok = (state == COLLECT) && !seed_load && (lfsr_state != 16'h0000);
  assign nib       = lfsr_state[3:0];
  assign accept    = (nib <= BCD_MAX);

  lfsr16_galois #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .step       (lfsr_step),
    .load       (seed_load),
    .load_value (seed_value),
    .state_out  (lfsr_state)
  );

  always_comb begin
    slot_nxt = slot;
    case (idx)
      2'd0:    slot_nxt[15:12] = nib;
      2'd1:    slot_nxt[11:8]  = nib;
      2'd2:    slot_nxt[7:4]   = nib;
      default: slot_nxt[3:0]   = nib;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      slot       <= 16'h0000;
      lfsr_digit <= 16'h0000;
      lfsr_latch <= 1'b0;
      busy       <= 1'b0;
      reject_cnt <= 8'd0;
    end else begin
      lfsr_latch <= 1'b0;
      case (state)
        IDLE: begin
          if (gen_req) begin
            state      <= COLLECT;
            busy       <= 1'b1;
            reject_cnt <= 8'd0;
            idx        <= 2'd0;
          end
        end
        COLLECT: begin
          if (sample_ok) begin
            if (accept) begin
              slot <= slot_nxt;
              idx  <= idx + 2'd1;
              if (idx == 2'd3) begin
                state      <= DONE;
                busy       <= 1'b0;
                lfsr_latch <= 1'b1;
                lfsr_digit <= slot_nxt;
              end
            end else if (reject_cnt != 8'hFF) begin
              reject_cnt <= reject_cnt + 8'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otp_generator.sv
// Directed bench for otp_generator with a deterministic (non free-running) LFSR.
module tb_otp_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        gen_req;
  logic        seed_load;
  logic [15:0] seed_value;
  logic [15:0] lfsr_digit;
  logic        lfsr_latch;
  logic        busy;
  logic [7:0]  reject_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] seed;
    logic [15:0] exp_state;
    logic [15:0] exp_otp;
    int          exp_rej;
  } vec_t;

  vec_t vecs[6];

  otp_generator #(
    .SEED     (16'hACE1),
    .TAPS     (16'hB400),
    .FREE_RUN (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gen_req    (gen_req),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .lfsr_digit (lfsr_digit),
    .lfsr_latch (lfsr_latch),
    .busy       (busy),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference LFSR: produces the next OTP from state s and returns the advanced state.
  function automatic logic [15:0] model_otp(input logic [15:0] s_in, output logic [15:0] s_out);
    logic [15:0] s;
    logic [15:0] otp;
    int          cnt;
    s   = s_in;
    otp = 16'h0000;
    cnt = 0;
    while (cnt < 4) begin
      if (s[3:0] <= 4'd9) begin
        otp = {otp[11:0], s[3:0]};
        cnt++;
      end
      s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
      if (s == 16'h0000) s = 16'hACE1;
    end
    s_out = s;
    return otp;
  endfunction

  task automatic load_seed(input logic [15:0] s);
    seed_load  = 1'b1;
    seed_value = s;
    tick();
    seed_load  = 1'b0;
  endtask

  task automatic run_req(input bit toggle, output logic [15:0] otp, output int rej,
                         output int busy_cycles, output int edges);
    bit seen;
    seen        = 1'b0;
    otp         = 16'h0000;
    rej         = 0;
    edges       = 0;
    gen_req     = 1'b1;
    tick();
    gen_req     = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (toggle && i < 3) gen_req = (i % 2 == 0);
      else gen_req = 1'b0;
      tick();
      edges++;
      if (lfsr_latch) begin
        seen = 1'b1;
        otp  = lfsr_digit;
        rej  = reject_cnt;
      end else if (busy) begin
        busy_cycles++;
      end
    end
    gen_req = 1'b0;
    chk("latch_seen", {31'd0, seen}, 32'd1);
    tick();
    chk("latch_single_cycle", {31'd0, lfsr_latch}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] otp;
    logic [15:0] m_state;
    logic [15:0] m_otp;
    int          rej;
    int          bcyc;
    int          edges;
    int          extra;
    bit          seen;
    bit          bcd_ok;

    vecs[0] = '{16'h0001, 16'h0001, 16'h1000, 0};
    vecs[1] = '{16'h000F, 16'h000F, 16'h7310, 1};
    vecs[2] = '{16'hACE1, 16'hACE1, 16'h1087, 2};
    vecs[3] = '{16'h0000, 16'hACE1, 16'h1087, 2};
    vecs[4] = '{16'h0009, 16'h0009, 16'h9421, 0};
    vecs[5] = '{16'h000A, 16'h000A, 16'h5210, 1};

    reset      = 1'b0;
    gen_req    = 1'b0;
    seed_load  = 1'b0;
    seed_value = 16'h0000;
    tick();
    tick();
    chk("reset_digit", {16'd0, lfsr_digit}, 32'h0);
    chk("reset_latch", {31'd0, lfsr_latch}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rej", {24'd0, reject_cnt}, 32'd0);
    chk("reset_lfsr", {16'd0, dut.u_lfsr.state_out}, 32'hACE1);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      load_seed(vecs[i].seed);
      chk("seed_state", {16'd0, dut.u_lfsr.state_out}, {16'd0, vecs[i].exp_state});
      run_req(1'b0, otp, rej, bcyc, edges);
      chk("vec_otp", {16'd0, otp}, {16'd0, vecs[i].exp_otp});
      chk("vec_rej", rej, vecs[i].exp_rej);
      chk("vec_busy_cycles", bcyc, 4 + vecs[i].exp_rej);
      chk("vec_latency", edges, 4 + vecs[i].exp_rej);
    end

    // Request toggled during COLLECT must not produce a second strobe.
    load_seed(16'h0001);
    run_req(1'b1, otp, rej, bcyc, edges);
    chk("toggle_otp", {16'd0, otp}, 32'h1000);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (lfsr_latch) extra++;
    end
    chk("toggle_no_extra_strobe", extra, 0);
    chk("digit_held", {16'd0, lfsr_digit}, 32'h1000);

    // Held request: 200 back-to-back OTPs checked against the reference model.
    load_seed(16'h0001);
    m_state = 16'h0001;
    gen_req = 1'b1;
    for (int n = 0; n < 200; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        tick();
        if (lfsr_latch) seen = 1'b1;
      end
      chk("b2b_latch_seen", {31'd0, seen}, 32'd1);
      m_otp = model_otp(m_state, m_state);
      chk("b2b_otp", {16'd0, lfsr_digit}, {16'd0, m_otp});
      bcd_ok = 1'b1;
      for (int d = 0; d < 4; d++) begin
        if (lfsr_digit[d*4 +: 4] > 4'd9) bcd_ok = 1'b0;
      end
      chk("b2b_digits_bcd", {31'd0, bcd_ok}, 32'd1);
      tick();
      chk("b2b_single_strobe", {31'd0, lfsr_latch}, 32'd0);
    end
    gen_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Reset in the middle of a collection after two accepted digits.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    tick();
    tick();
    chk("midreset_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midreset_digit", {16'd0, lfsr_digit}, 32'h0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_rej", {24'd0, reject_cnt}, 32'd0);
    chk("midreset_lfsr", {16'd0, dut.u_lfsr.state_out}, 32'hACE1);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (lfsr_latch) extra++;
    end
    chk("midreset_no_strobe", extra, 0);
    reset = 1'b1;
    tick();
    run_req(1'b0, otp, rej, bcyc, edges);
    chk("post_reset_otp", {16'd0, otp}, 32'h1087);
    chk("post_reset_rej", rej, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
